// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester burst-limited arbiter feeding one UART transmitter.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_avail,
  input  logic [7:0]  req0_data,
  output logic        req0_pop,
  input  logic        req1_avail,
  input  logic [7:0]  req1_data,
  output logic        req1_pop,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [1:0]  grant,
  output logic        idle,
  output logic [15:0] tx_count
);
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  burst_q, burst_d;
  logic [15:0] tx_count_q, tx_count_d;
  logic        req0_pop_q, req0_pop_d, req1_pop_q, req1_pop_d;
  logic        tx_start_q, tx_start_d, idle_q, idle_d;
  logic        pick1, same;
  always_comb begin
    // Contention keeps the owner until its burst is spent; a lone requester always wins.
    pick1 = (req0_avail & req1_avail) ?
            (grant_q[1] ? (burst_q < MAXB) : (grant_q[0] && burst_q >= MAXB)) : req1_avail;
    same = pick1 ? grant_q[1] : grant_q[0];
    state_d = state_q;
    tx_data_d = tx_data_q;
    grant_d = grant_q;
    burst_d = burst_q;
    tx_count_d = tx_count_q;
    req0_pop_d = 1'b0;
    req1_pop_d = 1'b0;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: if (!tx_busy && (req0_avail || req1_avail)) begin
        state_d = LOAD;
        tx_data_d = pick1 ? req1_data : req0_data;
        grant_d = pick1 ? 2'b10 : 2'b01;
        burst_d = same ? (burst_q < MAXB ? burst_q + 4'd1 : burst_q) : 4'd1;
        req0_pop_d = !pick1;
        req1_pop_d = pick1;
      end
      LOAD: begin
        state_d = START;
        tx_start_d = 1'b1;
        tx_count_d = tx_count_q + 16'd1;
      end
      START: state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
    idle_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tx_data_q <= 8'h00;
      grant_q <= 2'b00;
      burst_q <= 4'd0;
      tx_count_q <= 16'd0;
      req0_pop_q <= 1'b0;
      req1_pop_q <= 1'b0;
      tx_start_q <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_data_q <= tx_data_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      tx_count_q <= tx_count_d;
      req0_pop_q <= req0_pop_d;
      req1_pop_q <= req1_pop_d;
      tx_start_q <= tx_start_d;
      idle_q <= idle_d;
    end
  end
  assign req0_pop = req0_pop_q;
  assign req1_pop = req1_pop_q;
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant = grant_q;
  assign idle = idle_q;
  assign tx_count = tx_count_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter with FWFT FIFO and UART busy models.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_avail, req1_avail, req0_pop, req1_pop;
  logic [7:0]  req0_data, req1_data, tx_data;
  logic        tx_start, tx_busy, idle;
  logic [1:0]  grant;
  logic [15:0] tx_count;
  logic        force_busy = 1'b0;
  logic [7:0]  f0 [256];
  logic [7:0]  f1 [256];
  logic [7:0]  w0 = 8'd0, w1 = 8'd0, r0 = 8'd0, r1 = 8'd0;
  int          bcnt = 0, cyc = 0, nlog = 0, npop = 0, nstart = 0, both_pop = 0;
  logic [1:0]  log_g [64];
  logic [7:0]  log_d [64];
  int          log_t [64];
  int          total = 0, bad = 0;

  uart_tx_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0_avail(req0_avail), .req0_data(req0_data), .req0_pop(req0_pop),
    .req1_avail(req1_avail), .req1_data(req1_data), .req1_pop(req1_pop),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .idle(idle), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  assign req0_avail = r0 != w0;
  assign req1_avail = r1 != w1;
  assign req0_data = f0[r0];
  assign req1_data = f1[r1];
  assign tx_busy = force_busy | (bcnt != 0);

  // FIFO pops, busy model (rises one cycle after tx_start, high 10 cycles) and start log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req0_pop) r0 <= r0 + 8'd1;
    if (req1_pop) r1 <= r1 + 8'd1;
    if (req0_pop || req1_pop) npop <= npop + 1;
    if (req0_pop && req1_pop) both_pop <= both_pop + 1;
    if (tx_start) bcnt <= 10;
    else if (bcnt > 0) bcnt <= bcnt - 1;
    if (tx_start) begin
      log_g[nlog % 64] <= grant;
      log_d[nlog % 64] <= tx_data;
      log_t[nlog % 64] <= cyc;
      nlog <= nlog + 1;
      nstart <= nstart + 1;
    end
  end

  task automatic push0(input logic [7:0] b);
    f0[w0] = b;
    w0 = w0 + 8'd1;
  endtask

  task automatic push1(input logic [7:0] b);
    f1[w1] = b;
    w1 = w1 + 8'd1;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle && !tx_busy && !req0_avail && !req1_avail) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    total++; if (tx_count !== 16'h0000) begin bad++; $display("FAIL reset_count: got %h want 0000", tx_count); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", tx_data); end
    total++; if ({req0_pop, req1_pop, tx_start} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {req0_pop, req1_pop, tx_start}); end
    resetn = 1'b1;
  endtask

  task automatic test_single;
    bit ok;
    @(negedge clk);
    push0(8'hA5);
    @(posedge clk); #1;
    total++; if ({req0_pop, req1_pop, tx_start} !== 3'b100) begin bad++; $display("FAIL single_pop: got %b want 100", {req0_pop, req1_pop, tx_start}); end
    @(posedge clk); #1;
    total++; if ({req0_pop, tx_start} !== 2'b01) begin bad++; $display("FAIL single_start: got %b want 01", {req0_pop, tx_start}); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", tx_data); end
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", grant); end
    total++; if (tx_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", tx_count); end
    wait_quiet(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got busy want idle"); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_reset_mid;
    int viol = 0;
    int n = 0;
    @(negedge clk);
    push0(8'h77);
    while (!tx_busy && n < 30) begin @(negedge clk); n++; end
    total++; if (!tx_busy) begin bad++; $display("FAIL mid_reach_busy: got 0 want 1"); end
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_idle: got %b want 1", idle); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL mid_grant: got %b want 00", grant); end
    total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", tx_count); end
    @(negedge clk);
    push0(8'h66);
    repeat (15) begin
      @(negedge clk);
      if (req0_pop || req1_pop || tx_start) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL mid_pulses_in_reset: got %0d want 0", viol); end
    r0_drop();
    resetn = 1'b1;
  endtask

  // Discard the byte queued during reset so the next scenario starts from empty FIFOs.
  task automatic r0_drop;
    w0 = w0 - 8'd1;
  endtask

  task automatic test_contention;
    bit ok;
    int base, i0, i1;
    logic [11:0] gseq = 12'b1100_1111_0000;
    logic [1:0]  eg;
    logic [7:0]  ed;
    base = nlog;
    i0 = 0;
    i1 = 0;
    for (int i = 0; i < 6; i++) begin
      push0(8'h10 + 8'(i));
      push1(8'h20 + 8'(i));
    end
    wait_quiet(400, ok);
    total++; if (!ok || nlog - base !== 12) begin bad++; $display("FAIL cont_count: got %0d want 12", nlog - base); end
    for (int k = 0; k < 12 && base + k < nlog; k++) begin
      eg = gseq[k] ? 2'b10 : 2'b01;
      ed = gseq[k] ? 8'h20 + 8'(i1) : 8'h10 + 8'(i0);
      if (gseq[k]) i1++; else i0++;
      total++;
      if (log_g[(base + k) % 64] !== eg || log_d[(base + k) % 64] !== ed) begin
        bad++;
        $display("FAIL cont_xfer%0d: got g=%b d=%h want g=%b d=%h", k, log_g[(base + k) % 64], log_d[(base + k) % 64], eg, ed);
      end
    end
    total++; if (tx_count !== 16'd12) begin bad++; $display("FAIL cont_txcount: got %0d want 12", tx_count); end
  endtask

  task automatic test_single_burst;
    bit ok;
    int base = nlog;
    for (int i = 0; i < 7; i++) push1(8'h30 + 8'(i));
    wait_quiet(300, ok);
    total++; if (!ok || nlog - base !== 7) begin bad++; $display("FAIL burst_count: got %0d want 7", nlog - base); end
    for (int k = 0; k < 7 && base + k < nlog; k++) begin
      total++;
      if (log_g[(base + k) % 64] !== 2'b10 || log_d[(base + k) % 64] !== 8'h30 + 8'(k)) begin
        bad++;
        $display("FAIL burst_xfer%0d: got g=%b d=%h want g=10 d=%h", k, log_g[(base + k) % 64], log_d[(base + k) % 64], 8'h30 + 8'(k));
      end
      if (k > 0) begin
        total++;
        if (log_t[(base + k) % 64] - log_t[(base + k - 1) % 64] !== 14) begin
          bad++;
          $display("FAIL burst_gap%0d: got %0d want 14", k, log_t[(base + k) % 64] - log_t[(base + k - 1) % 64]);
        end
      end
    end
  endtask

  task automatic test_busy_block;
    bit ok;
    int viol = 0;
    @(negedge clk);
    force_busy = 1'b1;
    push0(8'h5A);
    repeat (20) begin
      @(negedge clk);
      if (req0_pop || req1_pop || tx_start) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL busy_blocked: got %0d pulses want 0", viol); end
    force_busy = 1'b0;
    @(posedge clk); #1;
    total++; if ({req0_pop, tx_start} !== 2'b10) begin bad++; $display("FAIL busy_pop: got %b want 10", {req0_pop, tx_start}); end
    @(posedge clk); #1;
    total++; if ({req0_pop, tx_start} !== 2'b01 || tx_data !== 8'h5A) begin bad++; $display("FAIL busy_start: got %b/%h want 01/5a", {req0_pop, tx_start}, tx_data); end
    wait_quiet(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout: got busy want idle"); end
  endtask

  task automatic test_wrap;
    bit ok;
    total++; if (tx_count !== 16'd20) begin bad++; $display("FAIL wrap_before: got %0d want 20", tx_count); end
    // Preload the counter just below the wrap point instead of running 65535 transfers.
    @(negedge clk);
    force dut.tx_count_q = 16'hFFFF;
    #1 release dut.tx_count_q;
    @(negedge clk);
    push0(8'hEE);
    wait_quiet(50, ok);
    total++; if (!ok || tx_count !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %h want 0000", tx_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_reset_mid;
    test_contention;
    test_single_burst;
    test_busy_block;
    test_wrap;
    total++; if (both_pop !== 0) begin bad++; $display("FAIL pop_exclusive: got %0d want 0", both_pop); end
    total++; if (npop !== nstart) begin bad++; $display("FAIL pop_vs_start: got %0d pops want %0d", npop, nstart); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
